// File: rtl/wb_config_loader_if.sv
// Bundles the bitstream stream input and the Wishbone write port of the config loader.
// master: the loader side; slave: the source/config-port side.
interface wb_config_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_addr_o;
  logic [31:0] wbm_data_o;
  logic        wbm_ack_i;

  modport master (
    input  s_data, s_valid, wbm_ack_i,
    output s_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_data_o
  );

  modport slave (
    output s_data, s_valid, wbm_ack_i,
    input  s_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_data_o
  );
endinterface

// File: rtl/wb_config_loader.sv
// Streams 32-bit configuration words into a Wishbone config port, one single-beat
// write per accepted word, with per-write ack timeout and completion/error status.
module wb_config_loader #(
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = 4,
  parameter int INC_ADDR  = 1,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [31:0]      start_addr,
  input  logic [CNT_W-1:0] word_count,
  wb_config_loader_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [31:0]     ADDR_INC = (INC_ADDR != 0) ? 32'(ADDR_STEP) : 32'd0;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] count_q;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] wd_next;

  assign wd_next     = words_done + CNT_W'(1);
  assign bus.s_ready = (state == S_FETCH);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= S_IDLE;
      count_q        <= '0;
      to_cnt         <= '0;
      bus.wbm_cyc_o  <= 1'b0;
      bus.wbm_stb_o  <= 1'b0;
      bus.wbm_we_o   <= 1'b0;
      bus.wbm_sel_o  <= 4'h0;
      bus.wbm_addr_o <= 32'd0;
      bus.wbm_data_o <= 32'd0;
      words_done     <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bus.wbm_addr_o <= start_addr;
            count_q        <= word_count;
            words_done     <= '0;
            error          <= 1'b0;
            state          <= (word_count == '0) ? S_DONE : S_FETCH;
          end
        end

        S_FETCH: begin
          if (bus.s_valid) begin
            bus.wbm_data_o <= bus.s_data;
            bus.wbm_cyc_o  <= 1'b1;
            bus.wbm_stb_o  <= 1'b1;
            bus.wbm_we_o   <= 1'b1;
            bus.wbm_sel_o  <= 4'hF;
            to_cnt         <= '0;
            state          <= S_WRITE;
          end
        end

        S_WRITE: begin
          // An ack on the same edge as the timeout limit still completes the write.
          if (bus.wbm_ack_i) begin
            bus.wbm_cyc_o  <= 1'b0;
            bus.wbm_stb_o  <= 1'b0;
            bus.wbm_we_o   <= 1'b0;
            bus.wbm_sel_o  <= 4'h0;
            words_done     <= wd_next;
            bus.wbm_addr_o <= bus.wbm_addr_o + ADDR_INC;
            state          <= (wd_next == count_q) ? S_DONE : S_FETCH;
          end else if (to_cnt == TO_LAST) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.wbm_we_o  <= 1'b0;
            bus.wbm_sel_o <= 4'h0;
            error         <= 1'b1;
            state         <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_config_loader.sv
// Directed/randomized bench for wb_config_loader: two instances (incrementing and
// fixed address) share one stimulus and are checked against a transfer-level model.
module tb_wb_config_loader;
  localparam int CNT_W     = 16;
  localparam int ADDR_STEP = 4;
  localparam int TIMEOUT   = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      start_addr;
  logic [CNT_W-1:0] word_count;
  logic             busy, done, error;
  logic [CNT_W-1:0] words_done;
  logic             busy_f, done_f, error_f;
  logic [CNT_W-1:0] words_done_f;

  int n_checks = 0;
  int n_fail   = 0;

  wb_config_loader_if bus ();
  wb_config_loader_if bus_f ();

  assign bus_f.s_data    = bus.s_data;
  assign bus_f.s_valid   = bus.s_valid;
  assign bus_f.wbm_ack_i = bus.wbm_ack_i;

  always #5 clk = ~clk;

  wb_config_loader #(.CNT_W(CNT_W), .ADDR_STEP(ADDR_STEP), .INC_ADDR(1), .TIMEOUT(TIMEOUT), .TO_W(8)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .start_addr(start_addr), .word_count(word_count),
    .bus(bus), .busy(busy), .done(done), .error(error), .words_done(words_done)
  );

  wb_config_loader #(.CNT_W(CNT_W), .ADDR_STEP(ADDR_STEP), .INC_ADDR(0), .TIMEOUT(TIMEOUT), .TO_W(8)) u_dut_fix (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .start_addr(start_addr), .word_count(word_count),
    .bus(bus_f), .busy(busy_f), .done(done_f), .error(error_f), .words_done(words_done_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_cyc", bus.wbm_cyc_o, 0);
    chk("rst_stb", bus.wbm_stb_o, 0);
    chk("rst_we", bus.wbm_we_o, 0);
    chk("rst_sel", bus.wbm_sel_o, 0);
    chk("rst_addr", bus.wbm_addr_o, 0);
    chk("rst_data", bus.wbm_data_o, 0);
    chk("rst_rdy", bus.s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_wd", words_done, 0);
    chk("rst_cyc_f", bus_f.wbm_cyc_o, 0);
  endtask

  // One complete transfer of n words; expected addresses are base + ADDR_STEP*i (mod 2^32).
  task automatic run_xfer(input logic [31:0] base, input int n, input int gap_max, input bit poke_start);
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
    int          dly;
    int          gap;
    start = 1'b1; start_addr = base; word_count = CNT_W'(n);
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err", error, 0);
    chk("start_wd", words_done, 0);
    chk("start_rdy", bus.s_ready, (n != 0));
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(gap_max, 0);
      for (int g = 0; g < gap; g++) begin
        bus.s_valid = 1'b0;
        bus.wbm_ack_i = 1'($urandom_range(1, 0));
        tick();
        bus.wbm_ack_i = 1'b0;
        chk("gap_cyc", bus.wbm_cyc_o, 0);
        chk("gap_rdy", bus.s_ready, 1);
        chk("gap_wd", words_done, i);
      end
      exp_data = $urandom;
      exp_addr = base + 32'(ADDR_STEP * i);
      bus.s_data = exp_data;
      bus.s_valid = 1'b1;
      tick();
      bus.s_valid = 1'b0;
      bus.s_data = $urandom;
      dly = $urandom_range(3, 0);
      for (int d = 0; d <= dly; d++) begin
        chk("wr_cyc", bus.wbm_cyc_o, 1);
        chk("wr_stb", bus.wbm_stb_o, 1);
        chk("wr_we", bus.wbm_we_o, 1);
        chk("wr_sel", bus.wbm_sel_o, 4'hF);
        chk("wr_addr", bus.wbm_addr_o, exp_addr);
        chk("wr_data", bus.wbm_data_o, exp_data);
        chk("wr_rdy", bus.s_ready, 0);
        chk("wr_addr_fix", bus_f.wbm_addr_o, base);
        chk("wr_cyc_fix", bus_f.wbm_cyc_o, 1);
        if (d == dly) bus.wbm_ack_i = 1'b1;
        if (poke_start && d == 0) begin
          start = 1'b1;
          word_count = CNT_W'(n + 3);
          start_addr = ~base;
        end
        tick();
        bus.wbm_ack_i = 1'b0;
        start = 1'b0;
      end
      chk("ack_cyc", bus.wbm_cyc_o, 0);
      chk("ack_stb", bus.wbm_stb_o, 0);
      chk("ack_we", bus.wbm_we_o, 0);
      chk("ack_sel", bus.wbm_sel_o, 0);
      chk("ack_wd", words_done, i + 1);
      chk("ack_wd_fix", words_done_f, i + 1);
      chk("ack_done", done, 0);
      if (i < n - 1) chk("ack_rdy", bus.s_ready, 1);
    end
    chk("end_busy", busy, 1);
    chk("end_done_early", done, 0);
    tick();
    chk("end_done", done, 1);
    chk("end_done_fix", done_f, 1);
    chk("end_busy_idle", busy, 0);
    chk("end_wd", words_done, n);
    chk("end_err", error, 0);
    tick();
    chk("end_done_pulse", done, 0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; start_addr = '0; word_count = '0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.wbm_ack_i = 1'b0;
    tick();
    tick();
    chk_reset_state();
    rst = 1'b0;
    tick();

    run_xfer(32'h3000_0000, 3, 0, 1'b0);
    run_xfer(32'h3000_0040, 4, 5, 1'b0);
    run_xfer(32'h3000_0080, 0, 0, 1'b0);
    run_xfer(32'h3000_00C0, 3, 2, 1'b1);
    run_xfer(32'hFFFF_FFF8, 4, 1, 1'b0);

    // Write never acknowledged: abort after TIMEOUT cycles in WRITE.
    start = 1'b1; start_addr = 32'h3000_0100; word_count = CNT_W'(2);
    tick();
    start = 1'b0;
    bus.s_data = $urandom; bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    cnt = 0;
    while (bus.wbm_cyc_o === 1'b1 && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("to_cycles", cnt, TIMEOUT);
    chk("to_err", error, 1);
    chk("to_err_fix", error_f, 1);
    chk("to_done", done, 0);
    chk("to_busy", busy, 0);
    chk("to_wd", words_done, 0);
    chk("to_stb", bus.wbm_stb_o, 0);
    tick();
    chk("to_done_after", done, 0);
    chk("to_err_sticky", error, 1);
    run_xfer(32'h3000_0000, 1, 0, 1'b0);

    // Reset in the middle of a write.
    start = 1'b1; start_addr = 32'h3000_0200; word_count = CNT_W'(4);
    tick();
    start = 1'b0;
    bus.s_data = $urandom; bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    chk("mid_cyc", bus.wbm_cyc_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state();
    tick();
    run_xfer(32'h3000_0000, 2, 1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      run_xfer($urandom, $urandom_range(6, 1), 3, k[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
